// File: rtl/tron_plot_arbiter.sv
// tron_plot_arbiter
//   Serialises the two tron head positions into VGA plots. On each tick both
//   heads are captured. Each head is then checked against a 1-bit occupancy
//   bitmap and the arena walls. A surviving head is plotted and marked in the
//   bitmap. Player A is always handled before player B, so B's check sees
//   the cell A has just written.
//
// Ports
//   clk_i, resetn_i          : clock, asynchronous active-low reset
//   tick_i                   : one-cycle game tick; ax/ay/bx/by valid with it
//   ax_i, ay_i, bx_i, by_i   : head coordinates of players A and B
//   x_o, y_o, colour_o       : registered VGA plot coordinate and colour
//   plot_o                   : one-cycle VGA write enable
//   busy_o                   : high in every state except IDLE and HALT
//   dead_a_o, dead_b_o       : sticky per-player collision flags
//   game_over_o              : high while halted
//   tick_overrun_o           : sticky; a tick arrived while not in IDLE
module tron_plot_arbiter #(
  parameter int unsigned WIDTH    = 160,
  parameter int unsigned HEIGHT   = 120,
  parameter int unsigned ARENA_X0 = 10,
  parameter int unsigned ARENA_X1 = 149,
  parameter int unsigned ARENA_Y0 = 17,
  parameter int unsigned ARENA_Y1 = 108,
  parameter logic [2:0]  COLOUR_A = 3'b001,
  parameter logic [2:0]  COLOUR_B = 3'b100
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       tick_i,
  input  logic [7:0] ax_i,
  input  logic [6:0] ay_i,
  input  logic [7:0] bx_i,
  input  logic [6:0] by_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [2:0] colour_o,
  output logic       plot_o,
  output logic       busy_o,
  output logic       dead_a_o,
  output logic       dead_b_o,
  output logic       game_over_o,
  output logic       tick_overrun_o
);

  localparam int unsigned CELLS = WIDTH * HEIGHT;
  localparam logic [14:0] CELLS_A = 15'(CELLS);
  localparam logic [14:0] LAST_A  = 15'(CELLS - 1);

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_RD_A, S_CHK_A, S_WR_A, S_RD_B, S_CHK_B, S_WR_B, S_HALT
  } state_e;

  // The shift-add form hard-wires a 160-column row stride: y*160 = y*128 + y*32.
  function automatic logic [14:0] cell_addr(input logic [7:0] cx, input logic [6:0] cy);
    logic [14:0] yy;
    yy = {8'd0, cy};
    return (yy << 7) + (yy << 5) + {7'd0, cx};
  endfunction

  // Standing on a wall, or beyond it, is fatal. This also catches coordinates
  // outside the bitmap, so those never reach the RAM write port.
  function automatic logic is_wall(input logic [7:0] cx, input logic [6:0] cy);
    return (cx <= 8'(ARENA_X0)) || (cx >= 8'(ARENA_X1)) ||
           (cy <= 7'(ARENA_Y0)) || (cy >= 7'(ARENA_Y1));
  endfunction

  state_e      state_q, state_d;
  logic [14:0] clr_q, clr_d;
  logic [7:0]  ax_q, ax_d, bx_q, bx_d, x_q, x_d;
  logic [6:0]  ay_q, ay_d, by_q, by_d, y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        dead_a_q, dead_a_d, dead_b_q, dead_b_d;
  logic        ovr_q, ovr_d;

  logic        mem_we, mem_wdata, mem_re;
  logic [14:0] mem_waddr, mem_raddr;
  logic        occ_q;
  logic        mem_q [CELLS];

  logic [14:0] addr_a, addr_b;
  logic        wall_a, wall_b, same_cell;

  assign addr_a    = cell_addr(ax_q, ay_q);
  assign addr_b    = cell_addr(bx_q, by_q);
  assign wall_a    = is_wall(ax_q, ay_q);
  assign wall_b    = is_wall(bx_q, by_q);
  assign same_cell = (ax_q == bx_q) && (ay_q == by_q);

  // Occupancy bitmap: one write port and a registered read.
  // Out-of-range reads return 0; such heads are already dead by the wall test.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (mem_re) occ_q <= (mem_raddr < CELLS_A) ? mem_q[mem_raddr] : 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    bx_d      = bx_q;
    by_d      = by_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    dead_a_d  = dead_a_q;
    dead_b_d  = dead_b_q;
    ovr_d     = ovr_q | (tick_i && (state_q != S_IDLE));
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    mem_waddr = clr_q;
    mem_re    = 1'b0;
    mem_raddr = addr_a;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        clr_d  = clr_q + 15'd1;
        if (clr_q == LAST_A) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (tick_i) begin
          ax_d    = ax_i;
          ay_d    = ay_i;
          bx_d    = bx_i;
          by_d    = by_i;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_re  = 1'b1;
        state_d = S_CHK_A;
      end
      S_CHK_A: begin
        // The plot registers load here so that they are valid in WR_A.
        dead_a_d = dead_a_q | occ_q | wall_a | same_cell;
        if (!dead_a_d) begin
          plot_d   = 1'b1;
          x_d      = ax_q;
          y_d      = ay_q;
          colour_d = COLOUR_A;
        end
        state_d = S_WR_A;
      end
      S_WR_A: begin
        mem_we    = !dead_a_q;
        mem_waddr = addr_a;
        mem_wdata = 1'b1;
        state_d   = S_RD_B;
      end
      S_RD_B: begin
        mem_re    = 1'b1;
        mem_raddr = addr_b;
        state_d   = S_CHK_B;
      end
      S_CHK_B: begin
        dead_b_d = dead_b_q | occ_q | wall_b | same_cell;
        if (!dead_b_d) begin
          plot_d   = 1'b1;
          x_d      = bx_q;
          y_d      = by_q;
          colour_d = COLOUR_B;
        end
        state_d = S_WR_B;
      end
      S_WR_B: begin
        mem_we    = !dead_b_q;
        mem_waddr = addr_b;
        mem_wdata = 1'b1;
        state_d   = (dead_a_q || dead_b_q) ? S_HALT : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= S_CLEAR;
      clr_q    <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      dead_a_q <= 1'b0;
      dead_b_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      dead_a_q <= dead_a_d;
      dead_b_q <= dead_b_d;
      ovr_q    <= ovr_d;
    end
  end

  assign x_o            = x_q;
  assign y_o            = y_q;
  assign colour_o       = colour_q;
  assign plot_o         = plot_q;
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign dead_a_o       = dead_a_q;
  assign dead_b_o       = dead_b_q;
  assign game_over_o    = (state_q == S_HALT);
  assign tick_overrun_o = ovr_q;

endmodule

// File: tb/tb_tron_plot_arbiter.sv
module tb_tron_plot_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] ax = '0, bx = '0;
  logic [6:0] ay = '0, by = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, dead_a, dead_b, game_over, tick_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tron_plot_arbiter dut (
    .clk_i(clk), .resetn_i(resetn), .tick_i(tick),
    .ax_i(ax), .ay_i(ay), .bx_i(bx), .by_i(by),
    .x_o(x), .y_o(y), .colour_o(colour), .plot_o(plot), .busy_o(busy),
    .dead_a_o(dead_a), .dead_b_o(dead_b), .game_over_o(game_over),
    .tick_overrun_o(tick_overrun)
  );

  // Reference model: the board as a plain array of cells plus the two flags.
  bit mocc [19200];
  bit mda, mdb;

  function automatic bit fatal(input int cx, input int cy);
    return cx <= 10 || cx >= 149 || cy <= 17 || cy >= 108;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 19200; i++) mocc[i] = 1'b0;
    mda = 1'b0;
    mdb = 1'b0;
  endtask

  task automatic model_tick(input int pax, input int pay, input int pbx, input int pby,
                            output bit pa, output bit pb, output bit go);
    bit same;
    same = (pax == pbx) && (pay == pby);
    mda  = mda | fatal(pax, pay) | same;
    if (!mda) mda = mocc[pay*160 + pax];
    pa = !mda;
    if (pa) mocc[pay*160 + pax] = 1'b1;
    mdb  = mdb | fatal(pbx, pby) | same;
    if (!mdb) mdb = mocc[pby*160 + pbx];
    pb = !mdb;
    if (pb) mocc[pby*160 + pbx] = 1'b1;
    go = mda | mdb;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_colour"}, 32'(colour), 0);
    chk({tag, "_plot"}, 32'(plot), 0);
    chk({tag, "_dead"}, {30'd0, dead_a, dead_b}, 0);
    chk({tag, "_gameover"}, 32'(game_over), 0);
    chk({tag, "_overrun"}, 32'(tick_overrun), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  // Called right after resetn rises; counts CLEAR cycles until busy drops.
  task automatic wait_clear(input bit clear_tick);
    int n = 0;
    int bad = 0;
    while (n < 20000) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (plot) bad++;
      tick = clear_tick && (n == 100);
    end
    tick = 1'b0;
    chk("clear_len", n, 19200);
    chk("clear_plot", bad, 0);
    chk("clear_overrun", 32'(tick_overrun), 32'(clear_tick));
    chk("clear_flags", {29'd0, dead_a, dead_b, game_over}, 0);
    model_clear();
  endtask

  task automatic do_reset(input bit clear_tick);
    @(posedge clk); #1;
    resetn = 1'b0;
    tick   = 1'b0;
    @(negedge clk);
    reset_values("rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_clear(clear_tick);
  endtask

  // One tick at cycle T, checked cycle by cycle through T+7.
  task automatic run_tick(input int pax, input int pay, input int pbx, input int pby,
                          input bit pa, input bit pb, input bit da, input bit db, input bit go);
    int bad_plot = 0;
    int bad_busy = 0;
    @(posedge clk); #1;
    tick = 1'b1;
    ax = 8'(pax); ay = 7'(pay); bx = 8'(pbx); by = 7'(pby);
    @(negedge clk);
    chk("idle_before_tick", 32'(busy), 0);
    @(posedge clk); #1;
    tick = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("plot_a", 32'(plot), 32'(pa));
        if (pa) begin
          chk("x_a", 32'(x), pax);
          chk("y_a", 32'(y), pay);
          chk("colour_a", 32'(colour), 1);
        end
        chk("dead_a", 32'(dead_a), 32'(da));
      end else if (k == 6) begin
        chk("plot_b", 32'(plot), 32'(pb));
        if (pb) begin
          chk("x_b", 32'(x), pbx);
          chk("y_b", 32'(y), pby);
          chk("colour_b", 32'(colour), 4);
        end
        chk("dead_b", 32'(dead_b), 32'(db));
      end else begin
        if (plot) bad_plot++;
      end
      if (k < 7 && !busy) bad_busy++;
      if (k == 7) begin
        chk("busy_end", 32'(busy), 0);
        chk("game_over", 32'(game_over), 32'(go));
      end
    end
    chk("stray_plot", bad_plot, 0);
    chk("busy_pipe", bad_busy, 0);
  endtask

  // Ticks at T, T+3 (dropped, lands in WR_A) and T+7; reset lands at T+11.
  task automatic overrun_seq();
    int bad = 0;
    do_reset(1'b0);
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      tick = (c == 0) || (c == 3) || (c == 7);
      if (c == 0) begin ax = 8'd30; ay = 7'd40; bx = 8'd60; by = 7'd70; end
      if (c == 3) begin ax = 8'd90; ay = 7'd90; bx = 8'd95; by = 7'd95; end
      if (c == 7) begin ax = 8'd31; ay = 7'd40; bx = 8'd61; by = 7'd70; end
      @(negedge clk);
      case (c)
        3: begin
          chk("ovr_plot_a", 32'(plot), 1);
          chk("ovr_xy_a", {17'd0, x, y}, {17'd0, 8'd30, 7'd40});
        end
        4: chk("ovr_flag", 32'(tick_overrun), 1);
        6: begin
          chk("ovr_plot_b", 32'(plot), 1);
          chk("ovr_xy_b", {17'd0, x, y}, {17'd0, 8'd60, 7'd70});
          chk("ovr_colour_b", 32'(colour), 4);
        end
        7: chk("ovr_idle_t7", 32'(busy), 0);
        10: begin
          chk("ovr_plot_a2", 32'(plot), 1);
          chk("ovr_xy_a2", {17'd0, x, y}, {17'd0, 8'd31, 7'd40});
        end
        default: if (plot) bad++;
      endcase
    end
    chk("ovr_stray", bad, 0);
    @(posedge clk); #1;
    resetn = 1'b0;
    tick   = 1'b0;
    @(negedge clk);
    reset_values("midrst");
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_clear(1'b0);
  endtask

  task automatic halt_tick();
    int bad = 0;
    chk("overrun_before_halt_tick", 32'(tick_overrun), 0);
    @(posedge clk); #1;
    tick = 1'b1;
    ax = 8'd70; ay = 7'd70; bx = 8'd80; by = 7'd80;
    @(posedge clk); #1;
    tick = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (plot || busy) bad++;
    end
    chk("halt_no_plot", bad, 0);
    chk("halt_overrun", 32'(tick_overrun), 1);
    chk("halt_game_over", 32'(game_over), 1);
  endtask

  // Random survivable moves: fresh interior cells picked from the model board.
  task automatic random_phase();
    int rax, ray, rbx, rby;
    bit pa, pb, go;
    for (int t = 0; t < 10; t++) begin
      do begin
        rax = $urandom_range(148, 11);
        ray = $urandom_range(90, 18);
      end while (mocc[ray*160 + rax]);
      do begin
        rbx = $urandom_range(148, 11);
        rby = $urandom_range(90, 18);
      end while (mocc[rby*160 + rbx] || (rbx == rax && rby == ray));
      model_tick(rax, ray, rbx, rby, pa, pb, go);
      run_tick(rax, ray, rbx, rby, pa, pb, mda, mdb, go);
    end
  endtask

  typedef struct {
    int pre;  // 0 none, 1 reset, 2 random moves, 3 overrun sequence, 4 reset with tick in CLEAR
    int ax, ay, bx, by;
    bit pa, pb, da, db, go;
  } vec_t;

  vec_t vt [5];

  initial begin
    bit mpa, mpb, mgo;
    vt[0] = '{1, 25, 100, 100, 100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{2, 25, 100, 140, 105, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2] = '{3, 30,  40,  60,  70, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{0, 10,  50, 149,  60, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[4] = '{4, 50,  50,  50,  50, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    model_clear();
    for (int i = 0; i < 5; i++) begin
      case (vt[i].pre)
        1: do_reset(1'b0);
        2: random_phase();
        3: overrun_seq();
        4: do_reset(1'b1);
        default: ;
      endcase
      model_tick(vt[i].ax, vt[i].ay, vt[i].bx, vt[i].by, mpa, mpb, mgo);
      run_tick(vt[i].ax, vt[i].ay, vt[i].bx, vt[i].by,
               vt[i].pa, vt[i].pb, vt[i].da, vt[i].db, vt[i].go);
      if (i == 1) halt_tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
